// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
//   Shared types and constants for the key press classifier.
//   - DEF_*_CNT      : default timing constants (50 MHz system clock)
//   - KEY_IDLE_LEVEL : level of the active-low key when not pressed
//   - key_state_e    : classifier FSM state encoding
//   - key_dbg_t      : debug view of the FSM exported by the top level
//   - term_of()      : terminal count for a "count N cycles" counter
// -----------------------------------------------------------------------------
package key_pkg;

  // 20 ms debounce, 1 s long-press threshold, 200 ms auto-repeat at 50 MHz.
  localparam logic [31:0] DEF_DEBOUNCE_CNT = 32'd1_000_000;
  localparam logic [31:0] DEF_LONG_CNT     = 32'd50_000_000;
  localparam logic [31:0] DEF_REPEAT_CNT   = 32'd10_000_000;

  // The key is active low, so "released" is a 1.
  localparam logic KEY_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_PRESSED     = 3'd2,
    ST_LONG_HELD   = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } key_state_e;

  // Debug view: current state, whether the present press already went long,
  // and whether the timing parameters are in their legal range (all >= 1).
  typedef struct packed {
    key_state_e state;
    logic       long_flag;
    logic       cfg_ok;
  } key_dbg_t;

  // A counter that starts at 0 and must span cnt cycles fires at cnt-1.
  // A zero count is illegal; clamp it so the compare value stays sane.
  function automatic logic [31:0] term_of(input logic [31:0] cnt);
    return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
  endfunction

endpackage

// File: rtl/key_sync.sv
// -----------------------------------------------------------------------------
// key_sync
//   Two-flop synchronizer for the raw, asynchronous, active-low key input.
//   Both flops reset to the released level so no phantom press is seen while
//   or right after reset is asserted.
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   d   - raw asynchronous key level
//   q   - synchronized key level, two clk cycles behind d
// -----------------------------------------------------------------------------
module key_sync
  import key_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= KEY_IDLE_LEVEL;
      q    <= KEY_IDLE_LEVEL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_press_classifier.sv
// -----------------------------------------------------------------------------
// key_press_classifier
//   Debounces an active-low push button and classifies each press as short or
//   long, with optional auto-repeat while a long press is held.
//
//   Optional feature macro: KEY_REPEAT_EN
//     defined   -> repeat_pulse fires every REPEAT_CNT cycles in LONG_HELD
//     undefined -> repeat counter absent, repeat_pulse tied low
//
// Parameters:
//   DEBOUNCE_CNT - stable cycles needed to accept a level change (>= 1)
//   LONG_CNT     - cycles held after an accepted press until "long" (>= 1)
//   REPEAT_CNT   - auto-repeat interval in cycles (>= 1)
// Ports:
//   clk           - system clock, rising edge
//   rst           - asynchronous active-high reset
//   button_in     - raw key, active low, asynchronous to clk
//   button_out    - debounced key level, active low
//   press_pulse   - 1-cycle strobe on accepted press
//   release_pulse - 1-cycle strobe on accepted release
//   short_press   - 1-cycle strobe on release of a press that never went long
//   long_press    - 1-cycle strobe when the hold time reaches LONG_CNT
//   repeat_pulse  - 1-cycle strobe per REPEAT_CNT cycles while long-held
//   dbg           - FSM state, long flag and parameter sanity bit
//
// Every pulse output is a registered strobe: high for exactly one cycle, with
// no handshake; a consumer must sample it on every clock edge. All outputs are
// flops, so none of them glitches.
// -----------------------------------------------------------------------------
module key_press_classifier
  import key_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter logic [31:0] LONG_CNT     = DEF_LONG_CNT,
  parameter logic [31:0] REPEAT_CNT   = DEF_REPEAT_CNT
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     button_in,
  output logic     button_out,
  output logic     press_pulse,
  output logic     release_pulse,
  output logic     short_press,
  output logic     long_press,
  output logic     repeat_pulse,
  output key_dbg_t dbg
);

  localparam logic [31:0] DEB_TERM  = term_of(DEBOUNCE_CNT);
  localparam logic [31:0] LONG_TERM = term_of(LONG_CNT);
  localparam logic        CFG_OK    = (DEBOUNCE_CNT != 32'd0) &&
                                      (LONG_CNT     != 32'd0) &&
                                      (REPEAT_CNT   != 32'd0);

  // Synchronized key level (1 = released).
  logic btn_s;

  key_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_in),
    .q   (btn_s)
  );

  key_state_e  state;
  logic [31:0] deb_cnt;    // shared by press and release debounce
  logic [31:0] hold_cnt;   // time in PRESSED, frozen across a release bounce
  logic        long_flag;  // this press already declared long

`ifdef KEY_REPEAT_EN
  localparam logic [31:0] REP_TERM = term_of(REPEAT_CNT);
  logic [31:0] rep_cnt;    // time since entering LONG_HELD or last repeat
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      deb_cnt       <= 32'd0;
      hold_cnt      <= 32'd0;
      long_flag     <= 1'b0;
      button_out    <= KEY_IDLE_LEVEL;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt       <= 32'd0;
      repeat_pulse  <= 1'b0;
`endif
    end else begin
      // Strobes default low; the branch that fires one sets it for one cycle.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_pulse  <= 1'b0;
`endif

      case (state)
        ST_IDLE: begin
          if (!btn_s) begin
            state   <= ST_DEB_PRESS;
            deb_cnt <= 32'd0;
          end
        end

        ST_DEB_PRESS: begin
          if (btn_s) begin
            // Low glitch shorter than the debounce window: discard silently.
            state <= ST_IDLE;
          end else if (deb_cnt == DEB_TERM) begin
            state       <= ST_PRESSED;
            press_pulse <= 1'b1;
            button_out  <= 1'b0;
            hold_cnt    <= 32'd0;
            long_flag   <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + 32'd1;
          end
        end

        ST_PRESSED: begin
          // A release seen in the same cycle as the long terminal count wins,
          // so a press released right at the threshold still counts as short.
          if (btn_s) begin
            state   <= ST_DEB_RELEASE;
            deb_cnt <= 32'd0;
          end else if (hold_cnt == LONG_TERM) begin
            state      <= ST_LONG_HELD;
            long_press <= 1'b1;
            long_flag  <= 1'b1;
`ifdef KEY_REPEAT_EN
            rep_cnt    <= 32'd0;
`endif
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end

        ST_LONG_HELD: begin
          if (btn_s) begin
            state   <= ST_DEB_RELEASE;
            deb_cnt <= 32'd0;
          end
`ifdef KEY_REPEAT_EN
          else if (rep_cnt == REP_TERM) begin
            repeat_pulse <= 1'b1;
            rep_cnt      <= 32'd0;
          end else begin
            rep_cnt <= rep_cnt + 32'd1;
          end
`endif
        end

        ST_DEB_RELEASE: begin
          // hold_cnt / rep_cnt are untouched here so a high bounce resumes
          // the hold timing where it left off.
          if (!btn_s) begin
            state <= long_flag ? ST_LONG_HELD : ST_PRESSED;
          end else if (deb_cnt == DEB_TERM) begin
            state         <= ST_IDLE;
            button_out    <= KEY_IDLE_LEVEL;
            release_pulse <= 1'b1;
            short_press   <= ~long_flag;
          end else begin
            deb_cnt <= deb_cnt + 32'd1;
          end
        end

        default: begin
          // Unused encodings recover to a released, idle key.
          state      <= ST_IDLE;
          deb_cnt    <= 32'd0;
          button_out <= KEY_IDLE_LEVEL;
        end
      endcase
    end
  end

`ifndef KEY_REPEAT_EN
  assign repeat_pulse = 1'b0;
`endif

  assign dbg = '{state: state, long_flag: long_flag, cfg_ok: CFG_OK};

endmodule

// File: tb/tb_key_press_classifier.sv
// -----------------------------------------------------------------------------
// tb_key_press_classifier
//   Directed bench for key_press_classifier with DEBOUNCE_CNT=4, LONG_CNT=20,
//   REPEAT_CNT=8. Each directed case pushes its hand-computed pulse events
//   ({cycle, pulses}) into exp_q before driving the key; a negedge monitor pops
//   and compares whenever any pulse output is high. Compile with
//   +define+KEY_REPEAT_EN to also expect auto-repeat pulses.
//
//   Timing used for expectations: the key is driven just after posedge number
//   c; the pulse ending debounce of that edge shows up after posedge c+7
//   (2 synchronizer cycles + 1 idle-exit cycle + DEBOUNCE_CNT).
// -----------------------------------------------------------------------------
module tb_key_press_classifier;
  import key_pkg::*;

  localparam logic [31:0] DEB = 32'd4;
  localparam logic [31:0] LNG = 32'd20;
  localparam logic [31:0] REP = 32'd8;
  localparam int          W   = 37;

  // Pulse vector order: {press, release, short, long, repeat}
  localparam logic [4:0] EV_PRESS     = 5'b10000;
  localparam logic [4:0] EV_REL_SHORT = 5'b01100;
  localparam logic [4:0] EV_REL_LONG  = 5'b01000;
  localparam logic [4:0] EV_LONG      = 5'b00010;
  localparam logic [4:0] EV_REP       = 5'b00001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic button_in;

  logic     button_out;
  logic     press_pulse;
  logic     release_pulse;
  logic     short_press;
  logic     long_press;
  logic     repeat_pulse;
  key_dbg_t dbg;

  logic [31:0] cyc = 32'd0;
  int          tests = 0;
  int          fails = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  key_press_classifier #(
    .DEBOUNCE_CNT (DEB),
    .LONG_CNT     (LNG),
    .REPEAT_CNT   (REP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button_in     (button_in),
    .button_out    (button_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_press   (short_press),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .dbg           (dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic [31:0] at, input logic [4:0] ev);
    exp_q.push_back({at, ev});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [4:0]   mon_act;
  logic [W-1:0] mon_exp;

  always @(negedge clk) begin
    mon_act = {press_pulse, release_pulse, short_press, long_press, repeat_pulse};
    if (mon_act != 5'b0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pulse_unexpected: got pulses %b at cycle %0d, required none", mon_act, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_exp !== {cyc, mon_act}) begin
          fails++;
          $display("FAIL pulse_event: got pulses %b at cycle %0d, required pulses %b at cycle %0d",
                   mon_act, cyc, mon_exp[4:0], mon_exp[W-1:5]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] c0;
  logic [31:0] c1;

  initial begin
    rst       = 1'b1;
    button_in = 1'b1;
    idle(3);

    // Reset state
    check("rst_button_out", 32'(button_out), 32'd1);
    check("rst_pulses", 32'({press_pulse, release_pulse, short_press, long_press, repeat_pulse}), 32'd0);
    check("rst_state", 32'(dbg.state), 32'(ST_IDLE));
    check("rst_long_flag", 32'(dbg.long_flag), 32'd0);
    check("cfg_ok", 32'(dbg.cfg_ok), 32'd1);
    rst = 1'b0;
    idle(5);

    // Clean press 10 cycles then release: short press.
    c0 = cyc;
    expect_ev(c0 + 32'd7,  EV_PRESS);
    expect_ev(c0 + 32'd17, EV_REL_SHORT);
    button_in = 1'b0;
    idle(8);
    check("clean_button_out_low", 32'(button_out), 32'd0);
    check("clean_state_pressed", 32'(dbg.state), 32'(ST_PRESSED));
    idle(2);
    button_in = 1'b1;
    idle(12);
    check("clean_button_out_high", 32'(button_out), 32'd1);
    check("clean_state_idle", 32'(dbg.state), 32'(ST_IDLE));

    // Two-cycle low glitch: discarded, no events expected.
    c0 = cyc;
    button_in = 1'b0;
    idle(2);
    button_in = 1'b1;
    idle(2);
    check("glitch_state_deb_press", 32'(dbg.state), 32'(ST_DEB_PRESS));
    idle(4);
    check("glitch_state_idle", 32'(dbg.state), 32'(ST_IDLE));
    check("glitch_button_out", 32'(button_out), 32'd1);

    // Hold 40 cycles: long press; release seen in the same cycle as the
    // second repeat terminal count, so that repeat must not fire.
    c0 = cyc;
    expect_ev(c0 + 32'd7,  EV_PRESS);
    expect_ev(c0 + 32'd27, EV_LONG);
`ifdef KEY_REPEAT_EN
    expect_ev(c0 + 32'd35, EV_REP);
`endif
    expect_ev(c0 + 32'd47, EV_REL_LONG);
    button_in = 1'b0;
    idle(30);
    check("hold40_state_long", 32'(dbg.state), 32'(ST_LONG_HELD));
    check("hold40_long_flag", 32'(dbg.long_flag), 32'd1);
    idle(10);
    button_in = 1'b1;
    idle(12);
    check("hold40_state_idle", 32'(dbg.state), 32'(ST_IDLE));

    // Hold 50 cycles: several repeat intervals.
    c0 = cyc;
    expect_ev(c0 + 32'd7,  EV_PRESS);
    expect_ev(c0 + 32'd27, EV_LONG);
`ifdef KEY_REPEAT_EN
    expect_ev(c0 + 32'd35, EV_REP);
    expect_ev(c0 + 32'd43, EV_REP);
    expect_ev(c0 + 32'd51, EV_REP);
`endif
    expect_ev(c0 + 32'd57, EV_REL_LONG);
    button_in = 1'b0;
    idle(50);
    button_in = 1'b1;
    idle(12);

    // High bounce while PRESSED: hold_cnt freezes at 5 and resumes, so long
    // arrives 3 cycles later than an unbroken hold would give.
    c0 = cyc;
    expect_ev(c0 + 32'd7,  EV_PRESS);
    expect_ev(c0 + 32'd30, EV_LONG);
    expect_ev(c0 + 32'd40, EV_REL_LONG);
    button_in = 1'b0;
    idle(10);
    button_in = 1'b1;
    idle(2);
    button_in = 1'b0;
    idle(2);
    check("bounce_state_deb_release", 32'(dbg.state), 32'(ST_DEB_RELEASE));
    idle(1);
    check("bounce_state_pressed", 32'(dbg.state), 32'(ST_PRESSED));
    check("bounce_button_out", 32'(button_out), 32'd0);
    idle(18);
    button_in = 1'b1;
    idle(12);

    // Reset mid LONG_HELD with the key still held.
    c0 = cyc;
    expect_ev(c0 + 32'd7,  EV_PRESS);
    expect_ev(c0 + 32'd27, EV_LONG);
    button_in = 1'b0;
    idle(32);
    rst = 1'b1;
    #1;
    check("midrst_button_out", 32'(button_out), 32'd1);
    check("midrst_state", 32'(dbg.state), 32'(ST_IDLE));
    check("midrst_long_flag", 32'(dbg.long_flag), 32'd0);
    idle(2);
    rst = 1'b0;
    c1 = cyc;
    expect_ev(c1 + 32'd7,  EV_PRESS);
    expect_ev(c1 + 32'd17, EV_REL_SHORT);
    idle(8);
    check("postrst_button_out_low", 32'(button_out), 32'd0);
    idle(2);
    button_in = 1'b1;
    idle(12);

    // Release sampled when hold_cnt = LONG_CNT-1: release wins, short press.
    c0 = cyc;
    expect_ev(c0 + 32'd7,  EV_PRESS);
    expect_ev(c0 + 32'd31, EV_REL_SHORT);
    button_in = 1'b0;
    idle(24);
    button_in = 1'b1;
    idle(12);
    check("edge19_long_flag", 32'(dbg.long_flag), 32'd0);

    // One cycle later: long fires first, then a long release.
    c0 = cyc;
    expect_ev(c0 + 32'd7,  EV_PRESS);
    expect_ev(c0 + 32'd27, EV_LONG);
    expect_ev(c0 + 32'd32, EV_REL_LONG);
    button_in = 1'b0;
    idle(25);
    button_in = 1'b1;
    idle(12);
    check("edge20_state_idle", 32'(dbg.state), 32'(ST_IDLE));

    // Every expected event must have been seen.
    idle(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
